gba_rom_cache: RTL and testbench
================================

GBA_ROM_CACHE -- requirements
Module: gba_rom_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, giving line count = 2**INDEX_BITS (16 lines, 64 bits each).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic (~100 MHz, same clock as the SDRAM controller).
REQ-003 SHALL have port init, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port flush, input, 1, a one-cycle pulse that invalidates all lines.
REQ-005 SHALL have port cpu_addr, input, [26:1], the CPU halfword address.
REQ-006 SHALL have port cpu_req, input, 1, a one-cycle read request pulse.
REQ-007 SHALL have port cpu_dout, output, [15:0], the read data.
REQ-008 SHALL have port cpu_ready, output, 1, a one-cycle pulse meaning cpu_dout is valid.
REQ-009 SHALL have port mem_addr, output, [26:1], the line fill address; SHALL connect to SDRAM channel 1.
REQ-010 SHALL have port mem_req, output, 1, a one-cycle fill request pulse.
REQ-011 SHALL have port mem_dout, input, [63:0], the 4-halfword burst data.
REQ-012 SHALL have port mem_ready, input, 1, the burst-complete pulse.

Function
REQ-013 Address split SHALL be: word = cpu_addr[2:1]; index = cpu_addr[INDEX_BITS+2:3]; tag = cpu_addr[26:INDEX_BITS+3].
REQ-014 Storage per line SHALL be: valid bit, tag, and 64-bit data; halfword n SHALL be data[16n+15:16n].
REQ-015 State machine SHALL have states IDLE, FILL, WAIT_LAST and RESP.
REQ-016 IDLE hit (valid and tag match on cpu_req): cpu_ready and cpu_dout SHALL be driven on the next cycle, giving 1-cycle latency, and the state SHALL remain IDLE.
REQ-017 IDLE miss: the block SHALL latch the address, pulse mem_req for exactly one cycle with mem_addr = {cpu_addr[26:3], 2'b00}, and enter FILL.
REQ-018 FILL: the block SHALL wait for mem_ready; mem_req SHALL NOT be reasserted.
REQ-019 On mem_ready the block SHALL enter WAIT_LAST; mem_dout[63:48] becomes valid only on the cycle after mem_ready.
REQ-020 In WAIT_LAST the block SHALL capture mem_dout into the line, write the tag, set valid (subject to REQ-023), and enter RESP.
REQ-021 RESP: the block SHALL pulse cpu_ready with the requested halfword, taken from the captured data and not from the array read path, then return to IDLE.
REQ-022 Miss latency from cpu_req to cpu_ready SHALL equal the SDRAM latency + 3 cycles.
REQ-023 If flush occurs at any point in FILL or WAIT_LAST, the fill SHALL complete and respond to the CPU, but the line SHALL be left invalid.
REQ-024 If flush and cpu_req occur in the same IDLE cycle, the flush SHALL take precedence and the request SHALL be treated as a miss.
REQ-025 cpu_req while not in IDLE SHALL be ignored; requesters SHALL wait for cpu_ready (the bench flags any violation).
REQ-026 A refill of an index SHALL overwrite the previous tag and data (direct-mapped, no LRU).
REQ-027 The block SHALL have no write path; ROM writes bypass it, and the owner SHALL pulse flush after any ROM load.

Reset
REQ-028 init SHALL clear all valid bits, set state = IDLE, and drive mem_req = 0, cpu_ready = 0 and cpu_dout = 0.
REQ-029 init during FILL SHALL abandon the fill; the block SHALL ignore a subsequent stray mem_ready in IDLE, and no cpu_ready SHALL be issued.
REQ-030 Tag and data arrays SHALL need no reset and MAY be inferred as RAM or MLAB.

Structure
REQ-031 A shared package SHALL hold the state enum, the LINE_WORDS = 4 constant and the address-split widths, so that a future ch2 cache can reuse them.
REQ-032 One sub-module, gba_rom_cache_ram (tag+valid+data array with one read and one write port), is natural; the FSM SHALL remain in the top module.

Verification
REQ-033 After init, cpu_req addr 0x0000100 -> one mem_req with mem_addr 0x0000100 -> model returns 64'h4444_3333_2222_1111 -> cpu_dout 16'h1111 with one cpu_ready.
REQ-034 Then cpu_req addr 0x0000103 (word 3) -> cpu_ready on the next cycle with 16'h4444 and no mem_req.
REQ-035 Conflict: cpu_req addr 0x0000100 + (1 << 7) (same index, different tag) -> a miss and refill; a subsequent request to 0x0000100 misses again.
REQ-036 flush pulsed mid-fill -> the CPU still gets the correct data, and a repeat of the same address misses (mem_req issued).
REQ-037 flush and cpu_req in the same cycle on a cached address -> mem_req is issued and data is correct.
REQ-038 init asserted 2 cycles after mem_req, then mem_ready arrives -> no cpu_ready, state IDLE, and the next request to that address misses.

Source files
------------

// File: rtl/gba_rom_cache_pkg.sv
// Shared definitions for the GBA ROM line caches: FSM states, line geometry
// and address-split helpers so a second channel cache can reuse them.
package gba_rom_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WAIT_LAST,
      RESP
   } state_t;

   localparam int LINE_WORDS = 4;
   localparam int HALF_BITS  = 16;
   localparam int LINE_BITS  = LINE_WORDS * HALF_BITS;
   localparam int WORD_BITS  = 2;
   localparam int ADDR_MSB   = 26;
   localparam int ADDR_LSB   = 1;

   // Tag covers every address bit above the index field.
   function automatic int tag_bits(input int index_bits);
      return ADDR_MSB - (index_bits + WORD_BITS + ADDR_LSB) + 1;
   endfunction

   function automatic logic [HALF_BITS-1:0] pick_half(input logic [LINE_BITS-1:0] line,
                                                      input logic [WORD_BITS-1:0] word);
      return line[word*HALF_BITS +: HALF_BITS];
   endfunction

endpackage

// File: rtl/gba_rom_cache_ram.sv
// Direct-mapped line store: resettable valid bits plus tag/data arrays with
// one asynchronous read port and one write port.
import gba_rom_cache_pkg::*;

module gba_rom_cache_ram #(
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
   input  logic                  clk,
   input  logic                  init,
   input  logic                  clear,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [LINE_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic                  wr_valid,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [LINE_BITS-1:0]  wr_data
);

   localparam int LINES = 2 ** INDEX_BITS;

   logic [LINES-1:0]     valid;
   logic [TAG_BITS-1:0]  tags  [LINES];
   logic [LINE_BITS-1:0] lines [LINES];

   // A clear wins over a same-cycle write so a flushed fill never lands valid.
   always_ff @(posedge clk) begin
      if (init || clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         lines[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = lines[rd_index];

endmodule

// File: rtl/gba_rom_cache.sv
// Read-only direct-mapped cache in front of SDRAM channel 1 for GBA ROM
// fetches: single-cycle hits, 64-bit line refills on a miss.
import gba_rom_cache_pkg::*;

module gba_rom_cache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        init,
   input  logic        flush,
   input  logic [26:1] cpu_addr,
   input  logic        cpu_req,
   output logic [15:0] cpu_dout,
   output logic        cpu_ready,
   output logic [26:1] mem_addr,
   output logic        mem_req,
   input  logic [63:0] mem_dout,
   input  logic        mem_ready
);

   localparam int TAG_BITS = tag_bits(INDEX_BITS);

   state_t                 state;
   logic                   flushed;
   logic [26:1]            req_addr;
   logic [INDEX_BITS-1:0]  cpu_index;
   logic [INDEX_BITS-1:0]  req_index;
   logic [TAG_BITS-1:0]    cpu_tag;
   logic [TAG_BITS-1:0]    req_tag;
   logic                   rd_valid;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [LINE_BITS-1:0]   rd_data;
   logic                   wr_en;
   logic                   wr_valid;
   logic                   hit;

   assign cpu_index = cpu_addr[INDEX_BITS+2:3];
   assign cpu_tag   = cpu_addr[ADDR_MSB:INDEX_BITS+3];
   assign req_index = req_addr[INDEX_BITS+2:3];
   assign req_tag   = req_addr[ADDR_MSB:INDEX_BITS+3];

   // A flush in the request cycle forces a miss even if the line was present.
   assign hit      = rd_valid && (rd_tag == cpu_tag) && !flush;
   assign wr_en    = (state == WAIT_LAST);
   assign wr_valid = !(flushed || flush);

   gba_rom_cache_ram #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_ram (
      .clk      (clk),
      .init     (init),
      .clear    (flush),
      .rd_index (cpu_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (req_index),
      .wr_valid (wr_valid),
      .wr_tag   (req_tag),
      .wr_data  (mem_dout)
   );

   // cpu_ready is raised on entry to RESP so a miss costs SDRAM latency + 3;
   // the top halfword of the burst is only stable in WAIT_LAST, so capture there.
   always_ff @(posedge clk) begin
      if (init) begin
         state     <= IDLE;
         flushed   <= 1'b0;
         req_addr  <= '0;
         mem_addr  <= '0;
         mem_req   <= 1'b0;
         cpu_ready <= 1'b0;
         cpu_dout  <= '0;
      end else begin
         mem_req   <= 1'b0;
         cpu_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (hit) begin
                     cpu_ready <= 1'b1;
                     cpu_dout  <= pick_half(rd_data, cpu_addr[2:1]);
                  end else begin
                     req_addr <= cpu_addr;
                     mem_addr <= {cpu_addr[26:3], 2'b00};
                     mem_req  <= 1'b1;
                     flushed  <= 1'b0;
                     state    <= FILL;
                  end
               end
            end
            FILL: begin
               if (flush) begin
                  flushed <= 1'b1;
               end
               if (mem_ready) begin
                  state <= WAIT_LAST;
               end
            end
            WAIT_LAST: begin
               cpu_ready <= 1'b1;
               cpu_dout  <= pick_half(mem_dout, req_addr[2:1]);
               state     <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gba_rom_cache.sv
// Randomized self-checking bench for gba_rom_cache against a line-level cache
// model and a simple SDRAM responder with random latency.
module tb_gba_rom_cache;

   logic        clk = 1'b0;
   logic        init;
   logic        flush;
   logic [26:1] cpu_addr;
   logic        cpu_req;
   logic [15:0] cpu_dout;
   logic        cpu_ready;
   logic [26:1] mem_addr;
   logic        mem_req;
   logic [63:0] mem_dout;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   bit          mvalid [16];
   logic [19:0] mtag   [16];

   int          last_lat  = 0;
   int          force_lat = 0;
   logic [15:0] last_got;
   int          last_nreq;
   int          last_ready_at;
   bit          mon_en = 1'b0;
   logic        prev_ready = 1'b0;
   logic        prev_req   = 1'b0;

   always #5 clk = ~clk;

   gba_rom_cache #(.INDEX_BITS(4)) dut (
      .clk       (clk),
      .init      (init),
      .flush     (flush),
      .cpu_addr  (cpu_addr),
      .cpu_req   (cpu_req),
      .cpu_dout  (cpu_dout),
      .cpu_ready (cpu_ready),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_dout  (mem_dout),
      .mem_ready (mem_ready)
   );

   // ROM contents: one pinned line, everything else a multiplicative hash.
   function automatic logic [15:0] hash_half(input logic [26:1] a);
      logic [31:0] x;
      x = {6'd0, a} * 32'h9E37_79B1;
      return x[22:7];
   endfunction

   function automatic logic [63:0] line_data(input logic [26:1] la);
      if (la == 26'h100) return 64'h4444_3333_2222_1111;
      return {hash_half(la + 26'd3), hash_half(la + 26'd2),
              hash_half(la + 26'd1), hash_half(la)};
   endfunction

   function automatic logic [15:0] expected_half(input logic [26:1] a);
      logic [63:0] ld;
      int          w;
      ld = line_data({a[26:3], 2'b00});
      w  = int'(a[2:1]);
      return ld[16*w +: 16];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SDRAM channel responder; mem_dout[63:48] is junk on the mem_ready cycle.
   initial begin
      logic [63:0] d;
      int          lat;
      mem_ready = 1'b0;
      mem_dout  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req === 1'b1) begin
            d        = line_data(mem_addr);
            lat      = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
            last_lat = lat;
            repeat (lat) @(posedge clk);
            #1;
            mem_ready = 1'b1;
            mem_dout  = {16'hDEAD, d[47:0]};
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_dout  = d;
            @(posedge clk);
            #1;
            mem_dout = {$urandom, $urandom};
         end
      end
   end

   // Every cycle: cpu_ready and mem_req must be single-cycle pulses.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         checkOutput("ready_pulse_width", 64'(prev_ready && cpu_ready), 64'd0);
         checkOutput("mem_req_pulse_width", 64'(prev_req && mem_req), 64'd0);
      end
      prev_ready = cpu_ready;
      prev_req   = mem_req;
   end

   // One CPU read; flush_k < 0 means no flush, otherwise flush k cycles after the request.
   task automatic applyStimulus(input logic [26:1] addr, input int flush_k);
      logic [3:0]  idx;
      logic [19:0] tag;
      bit          hit;
      logic [15:0] exp;
      logic [26:1] seen_addr;
      int          n;
      int          ready_at;
      int          nreq;
      int          extra;
      idx       = addr[6:3];
      tag       = addr[26:7];
      hit       = (flush_k != 0) && mvalid[idx] && (mtag[idx] == tag);
      exp       = expected_half(addr);
      seen_addr = '0;
      n = 0; ready_at = 0; nreq = 0; extra = 0;
      cpu_addr = addr;
      cpu_req  = 1'b1;
      flush    = (flush_k == 0);
      while (n < 60 && (ready_at == 0 || n <= flush_k || n <= ready_at)) begin
         @(posedge clk);
         #1;
         n++;
         cpu_req = 1'b0;
         flush   = (n == flush_k);
         if (mem_req) begin
            nreq++;
            seen_addr = mem_addr;
         end
         if (cpu_ready) begin
            if (ready_at == 0) begin
               ready_at = n;
               last_got = cpu_dout;
            end else begin
               extra++;
            end
         end
      end
      flush = 1'b0;
      last_nreq     = nreq;
      last_ready_at = ready_at;
      checkOutput("ready_seen", 64'(ready_at != 0), 64'd1);
      if (hit) begin
         checkOutput("hit_latency", 64'(ready_at), 64'd1);
         checkOutput("hit_no_mem_req", 64'(nreq), 64'd0);
      end else begin
         checkOutput("miss_mem_req_count", 64'(nreq), 64'd1);
         checkOutput("miss_mem_addr", 64'(seen_addr), 64'({addr[26:3], 2'b00}));
         checkOutput("miss_latency", 64'(ready_at), 64'(last_lat + 3));
      end
      checkOutput("cpu_dout", 64'(last_got), 64'(exp));
      checkOutput("single_ready", 64'(extra), 64'd0);
      if (flush_k == 0) foreach (mvalid[i]) mvalid[i] = 1'b0;
      if (!hit) begin
         mvalid[idx] = 1'b1;
         mtag[idx]   = tag;
      end
      if (flush_k > 0) foreach (mvalid[i]) mvalid[i] = 1'b0;
   endtask

   // Reset two cycles after mem_req; the late burst must be ignored.
   task automatic applyInitDuringFill(input logic [26:1] addr);
      int nreq;
      int nready;
      int stray;
      nreq = 0; nready = 0; stray = 0;
      force_lat = 6;
      cpu_addr  = addr;
      cpu_req   = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         cpu_req = 1'b0;
         init    = (n == 3);
         if (mem_req) nreq++;
         if (cpu_ready) nready++;
         if (mem_ready) stray++;
      end
      init      = 1'b0;
      force_lat = 0;
      checkOutput("init_fill_mem_req", 64'(nreq), 64'd1);
      checkOutput("init_fill_stray_ready_seen", 64'(stray), 64'd1);
      checkOutput("init_fill_no_cpu_ready", 64'(nready), 64'd0);
      checkOutput("init_fill_dout_cleared", 64'(cpu_dout), 64'd0);
      foreach (mvalid[i]) mvalid[i] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [26:1] a;
      int          fk;
      init     = 1'b1;
      flush    = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = '0;
      foreach (mvalid[i]) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cpu_ready", 64'(cpu_ready), 64'd0);
      checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset_cpu_dout", 64'(cpu_dout), 64'd0);
      init   = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed: first miss and hit on line 0x100");
      applyStimulus(26'h100, -1);
      checkOutput("first_line_dout", 64'(last_got), 64'h1111);
      applyStimulus(26'h103, -1);
      checkOutput("word3_hit_dout", 64'(last_got), 64'h4444);
      checkOutput("word3_hit_latency", 64'(last_ready_at), 64'd1);

      $display("[TB] directed: index conflict");
      applyStimulus(26'h100 + 26'h80, -1);
      checkOutput("conflict_refill", 64'(last_nreq), 64'd1);
      applyStimulus(26'h100, -1);
      checkOutput("conflict_evicted", 64'(last_nreq), 64'd1);
      applyStimulus(26'h101, -1);
      checkOutput("reloaded_dout", 64'(last_got), 64'h2222);

      $display("[TB] directed: flush mid-fill and flush with request");
      applyStimulus(26'h200, 2);
      applyStimulus(26'h200, -1);
      checkOutput("flush_mid_fill_remiss", 64'(last_nreq), 64'd1);
      applyStimulus(26'h202, 0);
      checkOutput("flush_same_cycle_miss", 64'(last_nreq), 64'd1);

      $display("[TB] directed: init during fill");
      applyInitDuringFill(26'h3F8);
      applyStimulus(26'h3F8, -1);
      checkOutput("after_init_miss", 64'(last_nreq), 64'd1);

      $display("[TB] randomized reads");
      for (int i = 0; i < 300; i++) begin
         a  = {20'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         fk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         applyStimulus(a, fk);
      end

      repeat (4) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
